// File: rtl/traffic_light_ctrl.sv
// Two-road intersection phase sequencer with pedestrian walk phase.
// Lights are Moore-decoded from the state register; phase timing counts tick pulses.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state,
    output logic       phase_change
);

    typedef enum logic [2:0] {
        MainG = 3'd0,
        MainY = 3'd1,
        RedA  = 3'd2,
        SideG = 3'd3,
        SideY = 3'd4,
        Walk  = 3'd5,
        RedB  = 3'd6
    } state_e;

    localparam logic [2:0] LampR = 3'b100;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampG = 3'b001;

    // Terminal counts: timed states leave on the tick that sees cnt == dur-1.
    localparam logic [CNT_W-1:0] GreenMin   = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WalkLast   = CNT_W'(WALK_T - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ped_pend_q;
    logic             phase_change_q;
    logic             adv;
    logic             exit_now;
    logic             cnt_hold;

    always_comb begin
        adv      = enable && tick;
        state_d  = state_q;
        exit_now = 1'b0;
        case (state_q)
            // Minimum-green exit is not tick-gated; any enabled clock may leave.
            MainG: if (enable && cnt_q == GreenMin && (side_req || ped_pend_q)) begin
                exit_now = 1'b1;
                state_d  = MainY;
            end
            MainY: if (adv && cnt_q == YellowLast) begin
                exit_now = 1'b1;
                state_d  = RedA;
            end
            RedA: if (adv && cnt_q == AllRedLast) begin
                exit_now = 1'b1;
                state_d  = ped_pend_q ? Walk : SideG;
            end
            SideG: if (adv && cnt_q == GreenLast) begin
                exit_now = 1'b1;
                state_d  = SideY;
            end
            SideY: if (adv && cnt_q == YellowLast) begin
                exit_now = 1'b1;
                state_d  = RedB;
            end
            Walk: if (adv && cnt_q == WalkLast) begin
                exit_now = 1'b1;
                state_d  = RedB;
            end
            RedB: if (adv && cnt_q == AllRedLast) begin
                exit_now = 1'b1;
                state_d  = MainG;
            end
            default: begin
                exit_now = 1'b1;
                state_d  = MainG;
            end
        endcase
        cnt_hold = (state_q == MainG) && (cnt_q == GreenMin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= MainG;
            cnt_q          <= '0;
            ped_pend_q     <= 1'b0;
            phase_change_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_change_q <= exit_now;
            if (exit_now) begin
                cnt_q <= '0;
            end else if (adv && !cnt_hold) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Serving the walk clears the request even if the button is pressed again.
            if (state_q == RedA && state_d == Walk) begin
                ped_pend_q <= 1'b0;
            end else if (ped_req && state_q != Walk) begin
                ped_pend_q <= 1'b1;
            end
        end
    end

    always_comb begin
        main_light = LampR;
        side_light = LampR;
        walk       = 1'b0;
        case (state_q)
            MainG:   main_light = LampG;
            MainY:   main_light = LampY;
            SideG:   side_light = LampG;
            SideY:   side_light = LampY;
            Walk:    walk       = 1'b1;
            default: ;
        endcase
    end

    assign state        = state_q;
    assign phase_change = phase_change_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a vector table of tick-period spans
// with hand-computed phases, plus a back-to-back tick and reset-priority sequence.
module tb_traffic_light_ctrl;

    localparam logic [2:0] MG = 3'd0;
    localparam logic [2:0] MY = 3'd1;
    localparam logic [2:0] RA = 3'd2;
    localparam logic [2:0] SG = 3'd3;
    localparam logic [2:0] SY = 3'd4;
    localparam logic [2:0] WK = 3'd5;
    localparam logic [2:0] RB = 3'd6;
    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       tick = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] state;
    logic       phase_change;

    int checks = 0;
    int errors = 0;
    int pc_seen = 0;

    traffic_light_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .tick         (tick),
        .side_req     (side_req),
        .ped_req      (ped_req),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk         (walk),
        .state        (state),
        .phase_change (phase_change)
    );

    always #5 clk = ~clk;

    // One vector: optional reset cycle, then `ticks` periods of 4 cycles (tick on the first);
    // `ped` pulses ped_req on the first tick cycle of the span.
    typedef struct {
        logic       rst;
        logic       en;
        logic       side;
        logic       ped;
        int         ticks;
        logic [2:0] st;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       wk;
        int         pcs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic s, input logic p,
                       input int t, input logic [2:0] st, input logic [2:0] ml,
                       input logic [2:0] sl, input logic wk, input int pcs);
        vec_t v;
        v.rst = r; v.en = e; v.side = s; v.ped = p; v.ticks = t;
        v.st = st; v.ml = ml; v.sl = sl; v.wk = wk; v.pcs = pcs;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        pc_seen += int'(phase_change);
    endtask

    task automatic check_outs(input int idx, input logic [2:0] st, input logic [2:0] ml,
                              input logic [2:0] sl, input logic wk);
        chk("state", idx, 32'(state), 32'(st));
        chk("main_light", idx, 32'(main_light), 32'(ml));
        chk("side_light", idx, 32'(side_light), 32'(sl));
        chk("walk", idx, 32'(walk), 32'(wk));
    endtask

    initial begin
        // 1: idle main green
        add(1, 1, 0, 0, 0,  MG, LG, LR, 0, 0);
        add(0, 1, 0, 0, 60, MG, LG, LR, 0, 0);
        // 2: side request held from reset, full side cycle, then saturated-green exit
        add(1, 1, 1, 0, 0,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 0, 9,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 0, 1,  MY, LY, LR, 0, 1);
        add(0, 1, 1, 0, 3,  RA, LR, LR, 0, 1);
        add(0, 1, 1, 0, 1,  SG, LR, LG, 0, 1);
        add(0, 1, 1, 0, 9,  SG, LR, LG, 0, 0);
        add(0, 1, 1, 0, 1,  SY, LR, LY, 0, 1);
        add(0, 1, 1, 0, 3,  RB, LR, LR, 0, 1);
        add(0, 1, 1, 0, 1,  MG, LG, LR, 0, 1);
        add(0, 1, 1, 0, 9,  MG, LG, LR, 0, 0);
        add(0, 1, 0, 0, 1,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 0, 1,  MY, LY, LR, 0, 1);
        // 3: pedestrian only; press during WALK is ignored
        add(1, 1, 0, 0, 0,  MG, LG, LR, 0, 0);
        add(0, 1, 0, 0, 1,  MG, LG, LR, 0, 0);
        add(0, 1, 0, 1, 9,  MY, LY, LR, 0, 1);
        add(0, 1, 0, 0, 3,  RA, LR, LR, 0, 1);
        add(0, 1, 0, 0, 1,  WK, LR, LR, 1, 1);
        add(0, 1, 0, 1, 7,  WK, LR, LR, 1, 0);
        add(0, 1, 0, 0, 1,  RB, LR, LR, 0, 1);
        add(0, 1, 0, 0, 1,  MG, LG, LR, 0, 1);
        add(0, 1, 0, 0, 20, MG, LG, LR, 0, 0);
        // 4: pedestrian and side together, walk first
        add(1, 1, 0, 0, 0,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 1, 9,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 0, 1,  MY, LY, LR, 0, 1);
        add(0, 1, 1, 0, 3,  RA, LR, LR, 0, 1);
        add(0, 1, 1, 0, 1,  WK, LR, LR, 1, 1);
        add(0, 1, 1, 0, 8,  RB, LR, LR, 0, 1);
        add(0, 1, 1, 0, 1,  MG, LG, LR, 0, 1);
        add(0, 1, 1, 0, 9,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 0, 1,  MY, LY, LR, 0, 1);
        add(0, 1, 1, 0, 3,  RA, LR, LR, 0, 1);
        add(0, 1, 1, 0, 1,  SG, LR, LG, 0, 1);
        // 5: freeze in MAIN_Y; ped press while frozen still latches
        add(1, 1, 1, 0, 0,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 0, 10, MY, LY, LR, 0, 1);
        add(0, 1, 1, 0, 1,  MY, LY, LR, 0, 0);
        add(0, 0, 1, 1, 20, MY, LY, LR, 0, 0);
        add(0, 1, 1, 0, 1,  MY, LY, LR, 0, 0);
        add(0, 1, 1, 0, 1,  RA, LR, LR, 0, 1);
        add(0, 1, 1, 0, 1,  WK, LR, LR, 1, 1);
        // 6: reset mid SIDE_G with a pending pedestrian
        add(1, 1, 1, 0, 0,  MG, LG, LR, 0, 0);
        add(0, 1, 1, 0, 10, MY, LY, LR, 0, 1);
        add(0, 1, 1, 0, 3,  RA, LR, LR, 0, 1);
        add(0, 1, 1, 0, 1,  SG, LR, LG, 0, 1);
        add(0, 1, 1, 1, 3,  SG, LR, LG, 0, 0);
        add(1, 1, 0, 0, 0,  MG, LG, LR, 0, 0);
        add(0, 1, 0, 0, 12, MG, LG, LR, 0, 0);

        rst = 1'b1;
        step(0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            enable   = vecs[i].en;
            side_req = vecs[i].side;
            pc_seen  = 0;
            if (vecs[i].rst) begin
                rst = 1'b1;
                step(0);
                rst = 1'b0;
            end
            for (int t = 0; t < vecs[i].ticks; t++) begin
                ped_req = vecs[i].ped && (t == 0);
                step(1);
                ped_req = 1'b0;
                step(0);
                step(0);
                step(0);
            end
            check_outs(i, vecs[i].st, vecs[i].ml, vecs[i].sl, vecs[i].wk);
            chk("phase_change_count", i, 32'(pc_seen), 32'(vecs[i].pcs));
        end

        // Back-to-back ticks: every cycle counts; phase_change lasts one cycle.
        enable   = 1'b1;
        side_req = 1'b1;
        rst      = 1'b1;
        step(0);
        rst      = 1'b0;
        for (int i = 0; i < 10; i++) step(1);
        chk("b2b_min_green", 100, 32'(state), 32'(MG));
        step(1);
        chk("b2b_main_y", 101, 32'(state), 32'(MY));
        chk("b2b_pc_high", 101, 32'(phase_change), 32'd1);
        step(1);
        chk("b2b_pc_low", 102, 32'(phase_change), 32'd0);
        step(1);
        chk("b2b_still_y", 103, 32'(state), 32'(MY));
        step(1);
        chk("b2b_red_a", 104, 32'(state), 32'(RA));
        step(1);
        check_outs(105, SG, LR, LG, 1'b0);

        // Reset overrides a disabled block.
        enable = 1'b0;
        rst    = 1'b1;
        step(1);
        rst    = 1'b0;
        check_outs(106, MG, LG, LR, 1'b0);
        chk("rst_pc", 106, 32'(phase_change), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Phase sequencer for a two-road intersection with a pedestrian crossing. It converts a periodic `tick` pulse into per-phase interval timing, in the same style as the lab's tick-counting timeout counters. It sequences main-road, side-road and walk phases, with a guaranteed minimum main green and all-red clearance intervals. All light outputs are Moore-decoded from the state register, and the block drives the lamp/LED outputs directly.

## Interface

Parameters:
- `GREEN_T`, 10: main minimum green / side green duration, in ticks
- `YELLOW_T`, 3: yellow duration, in ticks (both roads)
- `ALLRED_T`, 1: all-red clearance duration, in ticks
- `WALK_T`, 8: walk duration, in ticks
- `CNT_W`, 4: phase counter width; must hold max(all durations); every duration is ≥1

Ports:
- `clk` input 1: single clock
- `rst` input 1: reset; one clock, synchronous, active-high
- `enable` input 1: high = run; low = freeze state and counter
- `tick` input 1: one-cycle timing pulse; counts only when `enable`=1
- `side_req` input 1: side-road vehicle sensor, level, not latched
- `ped_req` input 1: pedestrian button, any-length pulse, latched internally
- `main_light` output 3: {R,Y,G} for the main road
- `side_light` output 3: {R,Y,G} for the side road
- `walk` output 1: pedestrian walk lamp
- `state` output 3: current phase code (debug)
- `phase_change` output 1: registered one-cycle pulse, high in the first cycle of every new phase

## Operation

**States and codes:** MAIN_G=0, MAIN_Y=1, RED_A=2, SIDE_G=3, SIDE_Y=4, WALK=5, RED_B=6. Codes 7 and up are illegal and go to MAIN_G on the next clock.

**Light decode** (R=100, Y=010, G=001):

| State | `main_light` | `side_light` | `walk` |
|---|---|---|---|
| MAIN_G | G | R | 0 |
| MAIN_Y | Y | R | 0 |
| SIDE_G | R | G | 0 |
| SIDE_Y | R | Y | 0 |
| RED_A, RED_B | R | R | 0 |
| WALK | R | R | 1 |

**Phase counter `cnt`:**
- Cleared to 0 on every state transition.
- Otherwise increments on `enable && tick`.

**Timed states** (MAIN_Y, RED_A, SIDE_G, SIDE_Y, WALK, RED_B) use durations YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, WALK_T and ALLRED_T respectively.
- The state exits on the `enable && tick` cycle where `cnt == dur-1`.
- Each timed state therefore spans exactly `dur` ticks.

**MAIN_G:**
- `cnt` increments on ticks and saturates at GREEN_T, which marks minimum green as met.
- Exit to MAIN_Y happens on any clock with `enable`=1, `cnt == GREEN_T`, and (`side_req` or `ped_pend`). This exit is not tick-gated.
- With no request, the block stays in MAIN_G indefinitely.

**Transitions:**
- MAIN_Y → RED_A.
- RED_A → WALK if `ped_pend`, else SIDE_G. The pedestrian has priority.
- SIDE_G → SIDE_Y → RED_B.
- WALK → RED_B.
- RED_B → MAIN_G.

**`ped_pend` latch:**
- Set on any cycle with `ped_req`=1 while the state is not WALK. Setting is independent of `enable`.
- Cleared on the RED_A → WALK transition cycle. Clear wins over a simultaneous set.
- `ped_req` is ignored while in WALK.

**Pending side request:** if `side_req` is still high after WALK, it is served after the next MAIN_G minimum green.

**`enable`=0:**
- No state change and no `cnt` change; `tick` is ignored.
- Outputs hold.
- `ped_pend` may still set.

## Timing

- **Reset:** `rst`=1 sampled at a clock edge gives, in the next cycle:
  - state=MAIN_G, `cnt`=0, `ped_pend`=0, `phase_change`=0
  - `main_light`=001, `side_light`=100, `walk`=0
- **Reset priority:** `rst` overrides `enable` and every transition, including mid-phase.
- **Output latency:** lights, `walk` and `state` follow the state register combinationally, so they change in the cycle after the transition edge.
- **`phase_change`:** asserted in that same first cycle of the new phase, for one cycle only.
- **Tick-to-exit:** a timed state leaves on the clock edge of its final tick. The new phase is visible on the next cycle.
- **Back-to-back ticks** (tick high every cycle) are legal; each cycle counts.
- **Duration 1:** the state exits on its first tick.

## Test plan

All cases use default parameters and `tick` every 4th cycle.

1. Reset, then 60 ticks with no requests → remains MAIN_G; `main_light`=001, `side_light`=100; `phase_change` never asserts.
2. `side_req`=1 held from reset → MAIN_G for 10 ticks; MAIN_Y on the cycle after the 10th tick; then MAIN_Y 3 ticks, RED_A 1, SIDE_G 10, SIDE_Y 3, RED_B 1, back to MAIN_G. `phase_change` pulses once per entry.
3. `ped_req` single-cycle pulse at tick 2, `side_req`=0 → leaves MAIN_G after tick 10, then RED_A → WALK with `walk`=1 for 8 ticks → RED_B → MAIN_G. SIDE_G is never entered and `ped_pend`=0 afterwards.
4. `ped_req` pulse and `side_req` held → WALK is served first, MAIN_G holds a full 10 ticks, then the SIDE_G sequence runs.
5. `enable`=0 after 1 tick in MAIN_Y for 20 ticks → state and `cnt` frozen, `main_light`=010. After re-enable, exactly 2 more ticks reach RED_A.
6. `rst`=1 for one cycle mid SIDE_G with `ped_pend` set → next cycle MAIN_G, `cnt`=0, lights 001/100, `ped_pend` cleared.
